// File: rtl/vga_capture_if.sv
// ---------------------------------------------------------------------------
// vga_capture_if
//
// Groups the two streams around the VGA capture block:
//   video in  : h_sync, v_sync (active-low), r, g, b (4 bits each)
//   pixel out : pix_valid, pix_x, pix_y, pix_data ({b, g, r}), frame_start
//
// Modports:
//   master : the video source / pixel consumer (drives sync + colour)
//   slave  : the capture block (samples video, drives the pixel stream)
//
// Handshake: the pixel stream is valid-only. A beat is transferred on every
// clock where pix_valid is high; there is no ready, so the consumer must take
// every beat. pix_x/pix_y/pix_data are meaningful only when pix_valid is high
// and hold their previous values otherwise. frame_start is a standalone
// one-clock pulse, not qualified by pix_valid.
// ---------------------------------------------------------------------------
interface vga_capture_if;
    logic        h_sync;
    logic        v_sync;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;

    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [11:0] pix_data;
    logic        frame_start;

    modport master (
        output h_sync, v_sync, r, g, b,
        input  pix_valid, pix_x, pix_y, pix_data, frame_start
    );

    modport slave (
        input  h_sync, v_sync, r, g, b,
        output pix_valid, pix_x, pix_y, pix_data, frame_start
    );
endinterface

// File: rtl/vga_capture.sv
// ---------------------------------------------------------------------------
// vga_capture
//
// Receive side of a VGA link. Samples active-low h_sync/v_sync and 4:4:4 RGB
// on the pixel clock, recovers pixel coordinates, measures line and frame
// periods against the nominal mode and declares lock after LOCK_FRAMES
// consecutive good frames. While locked, active pixels are emitted as a
// registered (x, y, colour, valid) stream; while unlocked nothing is valid.
//
// Ports:
//   clk_25_175 : pixel clock, all logic on the rising edge
//   reset      : asynchronous, active-low, clears all state
//   vid        : vga_capture_if.slave (video in, pixel stream out)
//   locked     : high while in the LOCKED state
//   h_period   : last measured line length in clocks (saturates at 2047)
//   v_period   : last measured frame length in lines (saturates at 1023)
//   err_count  : number of lock losses, saturates at 255
//   state_dbg  : current FSM state (SEARCH=0, MEASURE=1, LOCKED=2)
// ---------------------------------------------------------------------------
module vga_capture #(
    parameter int NATIVE_HRES   = 640,
    parameter int FRONT_PORCH_H = 16,
    parameter int SYNC_PULSE_H  = 96,
    parameter int BACK_PORCH_H  = 48,
    parameter int NATIVE_VRES   = 480,
    parameter int FRONT_PORCH_V = 10,
    parameter int SYNC_PULSE_V  = 2,
    parameter int BACK_PORCH_V  = 33,
    parameter int LOCK_FRAMES   = 2
) (
    input  logic        clk_25_175,
    input  logic        reset,
    vga_capture_if.slave vid,
    output logic        locked,
    output logic [10:0] h_period,
    output logic [9:0]  v_period,
    output logic [7:0]  err_count,
    output logic [1:0]  state_dbg
);

    localparam int H_TOTAL = NATIVE_HRES + FRONT_PORCH_H + SYNC_PULSE_H + BACK_PORCH_H;
    localparam int V_TOTAL = NATIVE_VRES + FRONT_PORCH_V + SYNC_PULSE_V + BACK_PORCH_V;

    localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
    localparam logic [10:0] H_OFS     = 11'(SYNC_PULSE_H + BACK_PORCH_H);
    localparam logic [9:0]  V_OFS     = 10'(SYNC_PULSE_V + BACK_PORCH_V);
    localparam logic [10:0] H_RES_W   = 11'(NATIVE_HRES);
    localparam logic [9:0]  V_RES_W   = 10'(NATIVE_VRES);
    localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  good_cnt;
    logic        frame_bad;

    // Input stage S1 plus one delayed copy of the syncs for edge detection.
    logic        hs_s1, vs_s1, hs_s2, vs_s2;
    logic [11:0] rgb_s1;

    logic [10:0] hcnt, hcnt_inc, hcnt_nxt;
    logic [9:0]  vcnt, vcnt_inc, vcnt_nxt;
    logic        hs_fall, vs_fall;
    logic        line_len_ok, frame_len_ok;
    logic        line_bad, frame_bad_now, frame_good_now, lock_loss;
    logic [10:0] x_ofs;
    logic [9:0]  y_ofs;
    logic        active;

    logic        pix_valid_q, frame_start_q;
    logic [9:0]  pix_x_q, pix_y_q;
    logic [11:0] pix_data_q;

    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset) begin
            hs_s1  <= 1'b0;
            vs_s1  <= 1'b0;
            hs_s2  <= 1'b0;
            vs_s2  <= 1'b0;
            rgb_s1 <= '0;
        end else begin
            hs_s1  <= vid.h_sync;
            vs_s1  <= vid.v_sync;
            hs_s2  <= hs_s1;
            vs_s2  <= vs_s1;
            rgb_s1 <= {vid.b, vid.g, vid.r};
        end
    end

    // hcnt holds the index of the previous S1 sample; hcnt_nxt is the index
    // of the sample currently in S1, so coordinates are taken from the *_nxt
    // values to stay aligned with rgb_s1.
    always_comb begin
        hs_fall        = hs_s2 & ~hs_s1;
        vs_fall        = vs_s2 & ~vs_s1;
        hcnt_inc       = (hcnt == 11'h7FF) ? hcnt : hcnt + 11'd1;
        vcnt_inc       = (vcnt == 10'h3FF) ? vcnt : vcnt + 10'd1;
        hcnt_nxt       = hs_fall ? 11'd0 : hcnt_inc;
        vcnt_nxt       = vs_fall ? 10'd0 : (hs_fall ? vcnt_inc : vcnt);
        line_len_ok    = ({1'b0, hcnt} + 12'd1) == H_TOTAL_W;
        frame_len_ok   = ({1'b0, vcnt} + 11'd1) == V_TOTAL_W;
        // The line ending on this edge belongs to the frame ending here too.
        line_bad       = hs_fall & ~line_len_ok;
        frame_bad_now  = vs_fall & (~frame_len_ok | frame_bad | line_bad);
        frame_good_now = vs_fall & ~frame_bad_now;
        lock_loss      = (state == LOCKED) & (line_bad | frame_bad_now);
        // Unsigned offsets: anything left of / above the active window wraps
        // to a large value and fails the compare.
        x_ofs          = hcnt_nxt - H_OFS;
        y_ofs          = vcnt_nxt - V_OFS;
        active         = (x_ofs < H_RES_W) && (y_ofs < V_RES_W);
    end

    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset) begin
            hcnt     <= '0;
            vcnt     <= '0;
            h_period <= '0;
            v_period <= '0;
        end else begin
            hcnt <= hcnt_nxt;
            vcnt <= vcnt_nxt;
            if (hs_fall) begin
                h_period <= hcnt_inc;
            end
            if (vs_fall) begin
                v_period <= vcnt_inc;
            end
        end
    end

    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            good_cnt  <= '0;
            locked    <= 1'b0;
            err_count <= '0;
            frame_bad <= 1'b0;
        end else begin
            if (vs_fall) begin
                frame_bad <= 1'b0;
            end else if (line_bad) begin
                frame_bad <= 1'b1;
            end

            case (state)
                SEARCH: begin
                    if (vs_fall) begin
                        state    <= MEASURE;
                        good_cnt <= '0;
                    end
                end
                MEASURE: begin
                    if (frame_good_now) begin
                        if (good_cnt + 4'd1 == LOCK_N) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + 4'd1;
                        end
                    end else if (line_bad || frame_bad_now) begin
                        good_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (lock_loss) begin
                        state    <= MEASURE;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end
                end
                default: begin
                    state    <= SEARCH;
                    locked   <= 1'b0;
                    good_cnt <= '0;
                end
            endcase
        end
    end

    // Output register. pix_valid already excludes the cycle in which lock is
    // being lost so it drops together with locked.
    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset) begin
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_data_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            pix_valid_q   <= (state == LOCKED) && !lock_loss && active;
            frame_start_q <= (state == LOCKED) && vs_fall;
            if ((state == LOCKED) && !lock_loss && active) begin
                pix_x_q    <= x_ofs[9:0];
                pix_y_q    <= y_ofs;
                pix_data_q <= rgb_s1;
            end
        end
    end

    assign vid.pix_valid   = pix_valid_q;
    assign vid.pix_x       = pix_x_q;
    assign vid.pix_y       = pix_y_q;
    assign vid.pix_data    = pix_data_q;
    assign vid.frame_start = frame_start_q;
    assign state_dbg       = state;

endmodule

// File: tb/tb_vga_capture.sv
// ---------------------------------------------------------------------------
// tb_vga_capture
//
// Drives a reduced-size VGA mode (7 clocks x 6 lines) so that many frames fit
// in a short run. Pixel colour is {y[3:0], x[7:0]}; blanking carries random
// colour. A frame-level model tracks the expected lock state and pushes every
// active pixel that should come out as valid onto exp_q; the monitor pops and
// compares whenever pix_valid is high.
// ---------------------------------------------------------------------------
module tb_vga_capture;

    localparam int HRES  = 4;
    localparam int HFP   = 1;
    localparam int HSP   = 1;
    localparam int HBP   = 1;
    localparam int HTOT  = HRES + HFP + HSP + HBP;
    localparam int VRES  = 3;
    localparam int VFP   = 1;
    localparam int VSP   = 1;
    localparam int VBP   = 1;
    localparam int VTOT  = VRES + VFP + VSP + VBP;
    localparam int LOCKF = 2;

    // ---------------- clock / reset ----------------
    logic clk_25_175 = 1'b0;
    logic reset      = 1'b0;
    always #5 clk_25_175 = ~clk_25_175;

    vga_capture_if vid ();
    logic        locked;
    logic [10:0] h_period;
    logic [9:0]  v_period;
    logic [7:0]  err_count;
    logic [1:0]  state_dbg;

    vga_capture #(
        .NATIVE_HRES  (HRES),
        .FRONT_PORCH_H(HFP),
        .SYNC_PULSE_H (HSP),
        .BACK_PORCH_H (HBP),
        .NATIVE_VRES  (VRES),
        .FRONT_PORCH_V(VFP),
        .SYNC_PULSE_V (VSP),
        .BACK_PORCH_V (VBP),
        .LOCK_FRAMES  (LOCKF)
    ) dut (
        .clk_25_175(clk_25_175),
        .reset     (reset),
        .vid       (vid),
        .locked    (locked),
        .h_period  (h_period),
        .v_period  (v_period),
        .err_count (err_count),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard / model state ----------------
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_vfall_cyc = -100;
    int fs_count  = 0;
    int valid_cnt = 0;
    logic locked_q = 1'b0;

    int m_state;      // 0 search, 1 measure, 2 locked
    int m_good;
    int m_err;
    int m_lines;
    int m_clk_cnt = 0;
    bit m_frame_bad;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state     = 0;
        m_good      = 0;
        m_err       = 0;
        m_lines     = 0;
        m_frame_bad = 0;
    endtask

    // Called at the first clock of every line; vfall marks the first line
    // of a frame. Decides on the line/frame that just ended.
    task automatic model_line_start(bit vfall);
        int len;
        bit lbad;
        bit fgood;
        len       = m_clk_cnt;
        m_clk_cnt = 0;
        lbad      = (len != HTOT);
        fgood     = vfall && (m_lines + 1 == VTOT) && !m_frame_bad && !lbad;
        case (m_state)
            0: if (vfall) begin
                m_state = 1;
                m_good  = 0;
            end
            1: if (vfall && fgood) begin
                m_good++;
                if (m_good == LOCKF) begin
                    m_state = 2;
                    m_good  = 0;
                end
            end else if (lbad || vfall) begin
                m_good = 0;
            end
            default: if (lbad || (vfall && !fgood)) begin
                if (m_err < 255) m_err++;
                m_state = 1;
                m_good  = 0;
            end
        endcase
        if (vfall) begin
            m_lines     = 0;
            m_frame_bad = 0;
        end else begin
            m_lines++;
            if (lbad) m_frame_bad = 1;
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_pix_valid",   vid.pix_valid,   0);
        check_eq("rst_pix_x",       vid.pix_x,       0);
        check_eq("rst_pix_y",       vid.pix_y,       0);
        check_eq("rst_pix_data",    vid.pix_data,    0);
        check_eq("rst_frame_start", vid.frame_start, 0);
        check_eq("rst_locked",      locked,          0);
        check_eq("rst_h_period",    h_period,        0);
        check_eq("rst_v_period",    v_period,        0);
        check_eq("rst_err_count",   err_count,       0);
        check_eq("rst_state",       state_dbg,       0);
    endtask

    task automatic check_lock(string tag);
        check_eq(tag, locked, (m_state == 2) ? 1 : 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_line(int line, int len, int rst_at);
        for (int c = 0; c < len; c++) begin
            int x;
            int y;
            logic [31:0] xv;
            logic [31:0] yv;
            logic [11:0] col;
            bit act;
            @(negedge clk_25_175);
            if (c == 0) begin
                model_line_start(line == 0);
                if (line == 0) last_vfall_cyc = cyc;
            end
            if (c == rst_at) begin
                reset = 1'b0;
                exp_q.delete();
                model_reset();
            end
            if (rst_at >= 0 && c == rst_at + 2) check_reset_outputs();
            if (rst_at >= 0 && c == rst_at + 3) reset = 1'b1;
            x   = c - (HSP + HBP);
            y   = line - (VSP + VBP);
            act = (x >= 0) && (x < HRES) && (y >= 0) && (y < VRES);
            xv  = x;
            yv  = y;
            col = act ? {yv[3:0], xv[7:0]} : 12'($urandom_range(0, 4095));
            vid.h_sync = (c < HSP) ? 1'b0 : 1'b1;
            vid.v_sync = (line < VSP) ? 1'b0 : 1'b1;
            vid.r = col[3:0];
            vid.g = col[7:4];
            vid.b = col[11:8];
            m_clk_cnt++;
            if (act && m_state == 2) exp_q.push_back({xv[9:0], yv[9:0], col});
        end
    endtask

    task automatic drive_frame(int nlines, int bad_line, int rst_line);
        for (int l = 0; l < nlines; l++) begin
            drive_line(l, (l == bad_line) ? HTOT + 1 : HTOT, (l == rst_line) ? 3 : -1);
        end
    endtask

    task automatic hold_idle(int n);
        repeat (n) begin
            @(negedge clk_25_175);
            vid.h_sync = 1'b1;
            vid.v_sync = 1'b1;
            vid.r = 4'($urandom_range(0, 15));
            vid.g = 4'($urandom_range(0, 15));
            vid.b = 4'($urandom_range(0, 15));
            m_clk_cnt++;
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk_25_175);
            #1;
            cyc++;
            if (vid.pix_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) check_eq("sb_underflow", exp_q.size(), 1);
                else check_eq("pix", {vid.pix_x, vid.pix_y, vid.pix_data}, exp_q.pop_front());
            end
            if (vid.frame_start) begin
                fs_count++;
                check_eq("frame_start_cyc", cyc, last_vfall_cyc + 2);
            end
            if (locked && !locked_q) check_eq("lock_rise_cyc", cyc, last_vfall_cyc + 2);
            locked_q = locked;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        vid.h_sync = 1'b1;
        vid.v_sync = 1'b1;
        vid.r = '0;
        vid.g = '0;
        vid.b = '0;
        model_reset();
        repeat (3) @(negedge clk_25_175);
        check_reset_outputs();
        reset = 1'b1;
        hold_idle(3);

        // Acquire lock: third v_sync fall locks.
        drive_frame(VTOT, -1, -1);
        check_lock("lock_f0");
        drive_frame(VTOT, -1, -1);
        check_lock("lock_f1");
        check_eq("locked_before_3rd", locked, 0);
        drive_frame(VTOT, -1, -1);
        check_eq("locked_after_3rd", locked, 1);
        check_eq("h_period_ideal", h_period, HTOT);
        check_eq("v_period_ideal", v_period, VTOT);

        // Ideal locked frames.
        fs_count  = 0;
        valid_cnt = 0;
        repeat (3) drive_frame(VTOT, -1, -1);
        check_eq("frame_start_count", fs_count, 3);
        check_eq("valid_count", valid_cnt, 3 * HRES * VRES);
        check_eq("last_pix_x", vid.pix_x, HRES - 1);
        check_eq("last_pix_y", vid.pix_y, VRES - 1);
        check_eq("last_pix_data", vid.pix_data, 12'h203);

        // One line too long while locked.
        drive_frame(VTOT, 2, -1);
        check_eq("long_line_unlock", locked, 0);
        check_eq("long_line_err", err_count, 1);
        drive_frame(VTOT, -1, -1);
        check_lock("relock_a");
        drive_frame(VTOT, -1, -1);
        check_lock("relock_b");
        drive_frame(VTOT, -1, -1);
        check_eq("relock_done", locked, 1);

        // Frame one line short while locked.
        drive_frame(VTOT - 1, -1, -1);
        drive_frame(VTOT, -1, -1);
        check_eq("short_frame_unlock", locked, 0);
        check_eq("short_frame_v_period", v_period, VTOT - 1);
        check_eq("short_frame_err", err_count, 2);
        drive_frame(VTOT, -1, -1);
        drive_frame(VTOT, -1, -1);
        check_lock("relock_short");

        // Reset mid-line inside the active area.
        drive_frame(VTOT, -1, 3);
        check_eq("post_reset_err", err_count, 0);
        check_lock("post_reset_lock0");
        drive_frame(VTOT, -1, -1);
        check_lock("post_reset_lock1");
        drive_frame(VTOT, -1, -1);
        check_lock("post_reset_lock2");
        drive_frame(VTOT, -1, -1);
        check_eq("post_reset_relocked", locked, 1);

        // h_sync and v_sync stuck high.
        hold_idle(3000);
        check_eq("stuck_h_period_held", h_period, HTOT);
        check_eq("stuck_still_locked", locked, 1);
        drive_line(0, HTOT, -1);
        check_eq("stuck_h_period_sat", h_period, 2047);
        check_eq("stuck_unlock", locked, 0);
        check_eq("stuck_err", err_count, 1);
        for (int l = 1; l < VTOT; l++) drive_line(l, HTOT, -1);
        drive_frame(VTOT, -1, -1);
        drive_frame(VTOT, -1, -1);
        check_lock("relock_stuck");

        // Saturate the lock-loss counter.
        for (int i = 0; i < 256; i++) begin
            drive_frame(VTOT - 1, -1, -1);
            drive_frame(VTOT, -1, -1);
            drive_frame(VTOT, -1, -1);
        end
        check_eq("err_saturated", err_count, 255);
        check_eq("err_model", err_count, m_err);
        check_lock("final_lock");

        hold_idle(4);
        check_eq("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
# vga_capture

Receive-side counterpart to the VGA timing generator: consumes active-low h_sync/v_sync plus 4:4:4 RGB on the pixel clock and recovers pixel coordinates. It measures line and frame periods against the nominal mode, declares lock after consecutive good frames, and emits a registered pixel stream (x, y, 12-bit colour, valid) for loopback checking and frame capture. While unlocked, no pixel is reported valid.

## Interface
- NATIVE_HRES, 640, active pixels per line
- FRONT_PORCH_H, 16; SYNC_PULSE_H, 96; BACK_PORCH_H, 48: horizontal timing in clocks
- NATIVE_VRES, 480, active lines per frame
- FRONT_PORCH_V, 10; SYNC_PULSE_V, 2; BACK_PORCH_V, 33: vertical timing in lines
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)
- clk_25_175  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- h_sync  in  1  active-low horizontal sync
- v_sync  in  1  active-low vertical sync
- r, g, b  in  4 each  colour inputs
- pix_valid  out  1  pix_x/pix_y/pix_data are an active pixel
- pix_x  out  10  column 0..NATIVE_HRES-1
- pix_y  out  10  row 0..NATIVE_VRES-1
- pix_data  out  12  {b, g, r}, r in bits [3:0]
- frame_start  out  1  one-cycle pulse at the v_sync falling edge while locked
- locked  out  1  high in LOCKED state
- h_period  out  11  last measured line length in clocks
- v_period  out  10  last measured frame length in lines
- err_count  out  8  lock-loss count, saturates at 255

## Operation
- Every output resets to 0.
- Input stage: h_sync, v_sync, r, g, b registered once (stage S1). Edges are detected on S1 against its previous value.
- hcnt (11 b): cleared to 0 on an S1 h_sync falling edge, otherwise +1. Saturates at 2047.
- vcnt (10 b): cleared on an S1 v_sync falling edge. Incremented on each h_sync falling edge otherwise. Saturates at 1023. If both edges land in the same cycle, the clear wins.
- On each h_sync falling edge: h_period <= hcnt+1, the clocks since the previous falling edge. Good line when it equals H_TOTAL = sum of the four H params (800).
- On each v_sync falling edge: v_period <= vcnt+1. Good frame when it equals V_TOTAL (525) and every line in the frame was good.
- Coordinates:
  - x = hcnt − (SYNC_PULSE_H+BACK_PORCH_H)
  - y = vcnt − (SYNC_PULSE_V+BACK_PORCH_V)
  - Active when 0 ≤ x < NATIVE_HRES and 0 ≤ y < NATIVE_VRES, using unsigned compares on the offset counters.
- FSM:
  - SEARCH: wait for first v_sync falling edge, then MEASURE with good_cnt=0.
  - MEASURE: at each v_sync falling edge, a good frame increments good_cnt; when good_cnt reaches LOCK_FRAMES, go to LOCKED. A bad line or bad frame clears good_cnt and stays in MEASURE.
  - LOCKED: on any bad line or bad frame, err_count+1 (saturating), go to MEASURE with good_cnt=0, locked drops.
  - A bad line is detected at its terminating h_sync edge.
- pix_valid = LOCKED & active. pix_x, pix_y, pix_data are registered from S1 data and counters. When pix_valid=0, pix_x/pix_y/pix_data hold their last values.

## Timing
- Latency from input pins to pix_* outputs: 2 clocks (S1, then output register).
- frame_start is asserted on the same output cycle as the registered v_sync edge (2 clocks after the pin). It fires only while already LOCKED.
- Lock transition: locked rises 1 clock after the v_sync edge that completes the LOCK_FRAMES-th good frame. With LOCK_FRAMES=2, that is the 3rd v_sync falling edge after reset.
- Lock loss: locked falls 1 clock after the offending sync edge. pix_valid is low in that same cycle.
- Asynchronous reset mid-frame: all outputs 0 immediately. The FSM restarts in SEARCH; partial-frame measurements are discarded.
- h_sync/v_sync stuck high: counters saturate, no edges occur, state is unchanged. Lock is lost only at the next edge, when the measured period ≠ total.

## Test plan
- Ideal 800×525 stream from the generator, pixel colour = {y[3:0], x[7:0]}:
  - locked=1 after the 3rd v_sync fall; frame_start pulses once per frame.
  - pix_x=0, pix_y=0, pix_data=12'h000 first valid; pix_x=639, pix_y=479, pix_data=12'hF7F last valid.
  - Exactly 307200 valid cycles per frame.
- While locked, inject a single line of 801 clocks: locked falls 1 clock after that h_sync edge, err_count=1, and relock occurs after 2 further good frames.
- Frame of 524 lines while locked: lock lost at the v_sync edge, v_period=524, err_count increments.
- Assert reset mid-line 200 while locked: all outputs 0 during reset; no pix_valid until 3 v_sync falls after release.
- h_sync held high for 3000 clocks: hcnt saturates and h_period is not updated until the next edge; then h_period=2047 and lock is dropped.
- Force err_count to 255 with 256 lock losses: it stays at 255.
